// File: rtl/mac_array_seq.sv
// Job sequencer for the weight-stationary MAC array: clears tiles, streams the
// kernel and input vectors out of L0 as west-edge instructions, then drains.
module mac_array_seq #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_bw = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [len_bw-1:0] num_vec,
    input  logic              l0_empty,
    output logic              l0_rd,
    output logic [1:0]        inst_w,
    output logic              arr_reset,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = ((2 ** len_bw) > (row + col + 2)) ? (2 ** len_bw) : (row + col + 2);
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] COL_LAST   = CW'(col - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(row + col);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        EXEC  = 3'd4,
        DRAIN = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [len_bw-1:0] nv_q;
    logic [CW-1:0]     nv_last;
    logic              cnt_inc;

    assign nv_last = CW'(nv_q) - CW'(1);

    always_comb begin
        state_nxt = state;
        cnt_inc   = 1'b0;
        // A pop during reset would be lost anyway, so none is issued.
        l0_rd     = !reset && (state == LOAD || state == EXEC) && !l0_empty;
        case (state)
            IDLE:  if (start) state_nxt = CLR;
            CLR:   state_nxt = LOAD;
            LOAD: begin
                cnt_inc = l0_rd;
                if (l0_rd && cnt == COL_LAST) state_nxt = FLUSH;
            end
            FLUSH: begin
                cnt_inc = 1'b1;
                // Zero-vector jobs skip EXEC entirely so no cycle is spent there.
                if (cnt == COL_LAST) state_nxt = (nv_q == '0) ? DRAIN : EXEC;
            end
            EXEC: begin
                cnt_inc = l0_rd;
                if (l0_rd && cnt == nv_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                cnt_inc = 1'b1;
                if (cnt == DRAIN_LAST) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            nv_q   <= '0;
            inst_w <= 2'b00;
        end else begin
            state  <= state_nxt;
            inst_w <= {l0_rd && (state == EXEC), l0_rd && (state == LOAD)};
            if (state == IDLE && start) nv_q <= num_vec;
            if (state_nxt != state)     cnt  <= '0;
            else if (cnt_inc)           cnt  <= cnt + CW'(1);
        end
    end

    assign arr_reset = reset || (state == CLR);
    assign busy      = (state == CLR) || (state == LOAD) || (state == FLUSH) ||
                       (state == EXEC) || (state == DRAIN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_mac_array_seq.sv
// Randomized/directed bench for mac_array_seq; expected per-cycle outputs come
// from a schedule model built out of the L0 stall pattern for each job.
module tb_mac_array_seq;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int LBW = 8;
    localparam int NC  = 512;

    logic           clk = 1'b0;
    logic           reset, start, l0_empty;
    logic [LBW-1:0] num_vec;
    logic           l0_rd, arr_reset, busy, done;
    logic [1:0]     inst_w;

    always #5 clk = ~clk;

    mac_array_seq #(.row(ROW), .col(COL), .len_bw(LBW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_vec   (num_vec),
        .l0_empty  (l0_empty),
        .l0_rd     (l0_rd),
        .inst_w    (inst_w),
        .arr_reset (arr_reset),
        .busy      (busy),
        .done      (done)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int n_fail = 0;

    bit emp   [NC];
    int e_rd  [NC];
    int e_iw  [NC];
    int e_busy[NC];
    int e_done[NC];
    int e_arst[NC];

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic clr_emp();
        for (int i = 0; i < NC; i++) emp[i] = 1'b0;
    endtask

    task automatic rnd_emp(input int pct);
        for (int i = 0; i < NC; i++) emp[i] = (i < 400) && ($urandom_range(99) < pct);
    endtask

    // One job starting at relative cycle 0; returns the cycle done was observed.
    task automatic run_job(input int nv, input bit pulses, input int rst_at, output int done_cyc);
        int c, k, dn, last, nld, nex;
        for (int i = 0; i < NC; i++) begin
            e_rd[i] = 0; e_iw[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_arst[i] = 0;
        end
        e_arst[1] = 1;
        // load: first COL non-empty cycles from cycle 2; each pop -> 01 one cycle later
        c = 2; k = 0;
        while (k < COL) begin
            if (!emp[c]) begin e_rd[c] = 1; e_iw[c+1] = 1; k++; end
            c++;
        end
        c += COL;
        k = 0;
        while (k < nv) begin
            if (!emp[c]) begin e_rd[c] = 1; e_iw[c+1] = 2; k++; end
            c++;
        end
        c += ROW + COL + 1;
        dn = c;
        e_done[dn] = 1;
        for (int i = 1; i < dn; i++) e_busy[i] = 1;
        last = dn + 2;
        if (rst_at >= 0) begin
            e_rd[rst_at] = 0;
            e_arst[rst_at] = 1;
            for (int i = rst_at + 1; i < NC; i++) begin
                e_rd[i] = 0; e_iw[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_arst[i] = 0;
            end
            last = rst_at + 3;
        end

        done_cyc = -1; nld = 0; nex = 0;
        for (int cy = 0; cy <= last; cy++) begin
            start    = (cy == 0) || (pulses && (cy == 12 || cy == 30));
            l0_empty = emp[cy];
            reset    = (cy == rst_at);
            num_vec  = (cy == 0) ? LBW'(nv) : LBW'($urandom);
            @(negedge clk);
            chk("l0_rd", cy, 32'(l0_rd), 32'(e_rd[cy]));
            chk("inst_w", cy, 32'(inst_w), 32'(e_iw[cy]));
            chk("busy", cy, 32'(busy), 32'(e_busy[cy]));
            chk("done", cy, 32'(done), 32'(e_done[cy]));
            chk("arr_reset", cy, 32'(arr_reset), 32'(e_arst[cy]));
            if (inst_w == 2'b01) nld++;
            if (inst_w == 2'b10) nex++;
            if (done && done_cyc < 0) done_cyc = cy;
            @(posedge clk); #1;
        end
        start = 1'b0; reset = 1'b0; l0_empty = 1'b0;
        if (rst_at < 0) begin
            chk("n_load", nv, 32'(nld), 32'(COL));
            chk("n_exec", nv, 32'(nex), 32'(nv));
        end
    endtask

    initial begin
        int dc;
        reset = 1'b1; start = 1'b0; l0_empty = 1'b0; num_vec = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_inst_w", 0, 32'(inst_w), 32'd0);
        chk("rst_l0_rd", 0, 32'(l0_rd), 32'd0);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_arr_reset", 0, 32'(arr_reset), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // nominal job
        clr_emp();
        run_job(4, 1'b0, -1, dc);
        chk("done_cyc_nv4", 0, 32'(dc), 32'd39);

        // stalls in LOAD (5-6) and EXEC (21): schedule shifts by 3
        clr_emp();
        emp[5] = 1'b1; emp[6] = 1'b1; emp[21] = 1'b1;
        run_job(4, 1'b0, -1, dc);
        chk("done_cyc_stall", 0, 32'(dc), 32'd42);

        // zero vectors
        clr_emp();
        run_job(0, 1'b0, -1, dc);
        chk("done_cyc_nv0", 0, 32'(dc), 32'd35);

        // reset mid-LOAD, then a fresh job must match nominal timing
        clr_emp();
        run_job(4, 1'b0, 6, dc);
        run_job(4, 1'b0, -1, dc);
        chk("done_cyc_after_rst", 0, 32'(dc), 32'd39);

        // start pulses while busy are ignored
        run_job(4, 1'b1, -1, dc);
        chk("done_cyc_pulses", 0, 32'(dc), 32'd39);

        // full-range vector count
        run_job(255, 1'b0, -1, dc);
        chk("done_cyc_nv255", 0, 32'(dc), 32'd290);

        // random jobs with random L0 stalls
        for (int j = 0; j < 6; j++) begin
            rnd_emp(30);
            run_job(int'($urandom_range(0, 24)), 1'(j % 2), -1, dc);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
